// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised valid/ready pipeline stage register with flush and stall counter
// Ports: clk, reset (sync, active-high), flush_i (drop held entries and this cycle's input),
//   in_valid_i/in_ready_o/in_ctrl_i/in_data_i (upstream), out_valid_o/out_ready_i/out_ctrl_o/
//   out_data_o (downstream), occupancy_o (entries held), stall_cnt_o (saturating stalled cycles).
// Macro PIPE_SKID_EN: two-entry skid buffer with registered in_ready_o; undefined gives a
//   single register with a combinational ready path.
module pipe_stage_reg #(
    parameter int CTRL_W   = 8,
    parameter int DATA_W   = 101,
    parameter bit CLR_DATA = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    logic             in_fire, out_fire;
    logic [CNT_W-1:0] stall_q;

    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;
    assign stall_cnt_o = stall_q;

    // Flush deliberately leaves the counter alone; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset)
            stall_q <= '0;
        else if (out_valid_o && !out_ready_i && !(&stall_q))
            stall_q <= stall_q + 1'b1;
    end

`ifdef PIPE_SKID_EN
    typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;
    state_t            state_q;
    logic              rdy_q, vld_q;
    logic [CTRL_W-1:0] m_ctrl_q, s_ctrl_q;
    logic [DATA_W-1:0] m_data_q, s_data_q;

    assign in_ready_o  = rdy_q;
    assign out_valid_o = vld_q;
    assign out_ctrl_o  = m_ctrl_q;
    assign out_data_o  = m_data_q;
    assign occupancy_o = state_q;

    // Ready is a register that drops only when the skid slot fills, so out_ready_i
    // never reaches in_ready_o combinationally.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            state_q  <= EMPTY;
            rdy_q    <= 1'b1;
            vld_q    <= 1'b0;
            m_ctrl_q <= '0;
            s_ctrl_q <= '0;
            if (reset || CLR_DATA) begin
                m_data_q <= '0;
                s_data_q <= '0;
            end
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    state_q  <= HALF;
                    vld_q    <= 1'b1;
                    m_ctrl_q <= in_ctrl_i;
                    m_data_q <= in_data_i;
                end
                HALF: if (in_fire && out_fire) begin
                    m_ctrl_q <= in_ctrl_i;
                    m_data_q <= in_data_i;
                end else if (in_fire) begin
                    state_q  <= FULL;
                    rdy_q    <= 1'b0;
                    s_ctrl_q <= in_ctrl_i;
                    s_data_q <= in_data_i;
                end else if (out_fire) begin
                    state_q  <= EMPTY;
                    vld_q    <= 1'b0;
                    m_ctrl_q <= '0;
                end
                FULL: if (out_fire) begin
                    state_q  <= HALF;
                    rdy_q    <= 1'b1;
                    m_ctrl_q <= s_ctrl_q;
                    m_data_q <= s_data_q;
                    s_ctrl_q <= '0;
                    if (CLR_DATA) s_data_q <= '0;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end
`else
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign in_ready_o  = out_ready_i | ~valid_q;
    assign out_valid_o = valid_q;
    assign out_ctrl_o  = ctrl_q;
    assign out_data_o  = data_q;
    assign occupancy_o = {1'b0, valid_q};

    // A load wins over a drain, so simultaneous in/out fire keeps the stage valid.
    always_comb begin
        valid_d = flush_i ? 1'b0 : in_fire ? 1'b1      : out_fire ? 1'b0 : valid_q;
        ctrl_d  = flush_i ? '0   : in_fire ? in_ctrl_i : out_fire ? '0   : ctrl_q;
        data_d  = flush_i ? (CLR_DATA ? '0 : data_q) : in_fire ? in_data_i : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized self-checking bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;
    typedef struct packed {logic [7:0] c; logic [100:0] d;} ent_t;

    logic         clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]   in_ctrl = '0;
    logic [100:0] in_data = '0;
    logic         in_ready, out_valid, in_ready2, out_valid2;
    logic [7:0]   out_ctrl, out_ctrl2;
    logic [100:0] out_data, out_data2;
    logic [1:0]   occ, occ2;
    logic [15:0]  stall;
    logic [3:0]   stall2;

    ent_t mq[$];
    int   m_stall, m_stall4;
    int   errors = 0, checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_ctrl_o(out_ctrl), .out_data_o(out_data), .occupancy_o(occ), .stall_cnt_o(stall)
    );

    pipe_stage_reg #(.CNT_W(4), .CLR_DATA(1'b0)) dut2 (
        .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(out_valid2), .out_ready_i(out_ready),
        .out_ctrl_o(out_ctrl2), .out_data_o(out_data2), .occupancy_o(occ2), .stall_cnt_o(stall2)
    );

    function automatic bit model_ready();
`ifdef PIPE_SKID_EN
        return mq.size() < 2;
`else
        return out_ready || mq.size() == 0;
`endif
    endfunction

    function automatic logic [7:0] exp_ctrl();
        return mq.size() > 0 ? mq[0].c : 8'h00;
    endfunction

    // Advance the model by one clock using the inputs currently applied, then step the clock.
    task automatic tick();
        bit ir = model_ready();
        if (reset) begin
            mq.delete();
            m_stall  = 0;
            m_stall4 = 0;
        end else begin
            if (mq.size() > 0 && !out_ready) begin
                m_stall  = m_stall < 65535 ? m_stall + 1 : m_stall;
                m_stall4 = m_stall4 < 15 ? m_stall4 + 1 : m_stall4;
            end
            if (flush) mq.delete();
            else begin
                if (mq.size() > 0 && out_ready) void'(mq.pop_front());
                if (in_valid && ir) mq.push_back('{c: in_ctrl, d: in_data});
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [100:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_ctrl = 8'h7E; in_data = rand_data();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || stall !== 16'h0 || occ !== 2'd0 || out_data !== '0) begin
                errors++;
                $display("FAIL reset cyc%0d: valid=%b ctrl=%h stall=%0d occ=%0d want 0/00/0/0", i, out_valid, out_ctrl, stall, occ);
            end
        end
        reset = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_ctrl = 8'(i); in_data = rand_data();
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ctrl !== 8'(i) || out_data !== mq[0].d) begin
                errors++;
                $display("FAIL stream %0d: valid=%b ctrl=%h want 1/%h", i, out_valid, out_ctrl, 8'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || occ !== 2'd0) begin
            errors++;
            $display("FAIL stream drain: valid=%b occ=%0d want 0/0", out_valid, occ);
        end
    endtask

    task automatic test_stall();
        logic [100:0] d;
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'hA5; in_data = rand_data(); d = in_data;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ctrl !== 8'hA5 || out_data !== d) begin
                errors++;
                $display("FAIL stall hold %0d: valid=%b ctrl=%h want 1/a5", i, out_valid, out_ctrl);
            end
            if (i == 9) begin
                checks++;
                if (stall !== 16'd10) begin
                    errors++;
                    $display("FAIL stall count10: got %0d want 10", stall);
                end
            end
        end
        checks++;
        if (stall !== 16'd20 || stall2 !== 4'd15) begin
            errors++;
            $display("FAIL stall saturate: got %0d/%0d want 20/15", stall, stall2);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall release: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        logic [100:0] held;
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h5A; in_data = rand_data();
        tick();
`ifdef PIPE_SKID_EN
        in_ctrl = 8'h6B; in_data = rand_data();
        tick();
`endif
        held = mq[0].d;
        flush = 1'b1; out_ready = 1'b1; in_ctrl = 8'h33; in_data = rand_data();
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== '0 || occ !== 2'd0) begin
            errors++;
            $display("FAIL flush clr: valid=%b ctrl=%h occ=%0d data=%h want 0/00/0/0", out_valid, out_ctrl, occ, out_data);
        end
        checks++;
        if (out_valid2 !== 1'b0 || out_ctrl2 !== 8'h00 || out_data2 !== held) begin
            errors++;
            $display("FAIL flush hold: valid=%b ctrl=%h data=%h want 0/00/%h", out_valid2, out_ctrl2, out_data2, held);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_ctrl === 8'h33) begin
                errors++;
                $display("FAIL flush drop %0d: valid=%b ctrl=%h want 0/00", i, out_valid, out_ctrl);
            end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h11; in_data = rand_data();
        tick();
`ifdef PIPE_SKID_EN
        in_ctrl = 8'h22; in_data = rand_data();
        tick();
        in_valid = 1'b0;
        checks++;
        if (occ !== 2'd2 || in_ready !== 1'b0 || out_ctrl !== 8'h11) begin
            errors++;
            $display("FAIL skid full: occ=%0d rdy=%b ctrl=%h want 2/0/11", occ, in_ready, out_ctrl);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL skid ready path: rdy=%b want 0", in_ready);
        end
        tick();
        checks++;
        if (out_ctrl !== 8'h22 || occ !== 2'd1) begin
            errors++;
            $display("FAIL skid second: ctrl=%h occ=%0d want 22/1", out_ctrl, occ);
        end
`else
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || occ !== 2'd1) begin
            errors++;
            $display("FAIL single full: rdy=%b occ=%0d want 0/1", in_ready, occ);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single ready path: rdy=%b want 1", in_ready);
        end
        in_valid = 1'b1; in_ctrl = 8'h22; in_data = rand_data();
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 8'h22) begin
            errors++;
            $display("FAIL single swap: valid=%b ctrl=%h want 1/22", out_valid, out_ctrl);
        end
`endif
        tick();
        checks++;
        if (out_valid !== 1'b0 || occ !== 2'd0) begin
            errors++;
            $display("FAIL b2b drain: valid=%b occ=%0d want 0/0", out_valid, occ);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            flush     = $urandom_range(0, 31) == 0;
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            in_ctrl   = 8'($urandom);
            in_data   = rand_data();
            #1;
            checks++;
            if (in_ready !== model_ready() || in_ready2 !== model_ready()) begin
                errors++;
                $display("FAIL rand rdy %0d: got %b/%b want %b", i, in_ready, in_ready2, model_ready());
            end
            tick();
            checks++;
            if (out_valid !== (mq.size() > 0) || out_ctrl !== exp_ctrl() || occ !== 2'(mq.size())
                || out_ctrl2 !== exp_ctrl() || (mq.size() > 0 && out_data !== mq[0].d)) begin
                errors++;
                $display("FAIL rand out %0d: valid=%b ctrl=%h/%h occ=%0d want %b/%h/%0d", i, out_valid,
                         out_ctrl, out_ctrl2, occ, mq.size() > 0, exp_ctrl(), mq.size());
            end
            checks++;
            if (stall !== 16'(m_stall) || stall2 !== 4'(m_stall4)) begin
                errors++;
                $display("FAIL rand stall %0d: got %0d/%0d want %0d/%0d", i, stall, stall2, m_stall, m_stall4);
            end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
